// File: rtl/ctrl_seq.sv
// ---------------------------------------------------------------------------
// ctrl_seq -- multi-cycle instruction sequencer for the basic-computer CPU.
//
// Walks each instruction through FETCH -> DECODE -> (INDIRECT) -> EXEC_MEM or
// EXEC_REG. It talks to the memory port through a req/ack handshake and tells
// the datapath what to load and which operation to perform.
//
// Optional feature: define CTRL_TIMEOUT_EN to add a memory-timeout watchdog.
// The watchdog raises a sticky o_err and parks the block in HALT when a
// request goes unacknowledged for too long.
//
// Parameters
//   DW       instruction width (>= 8): ir[DW-1]=I, ir[DW-2:DW-4]=opcode,
//            ir[DW-5:0]=address / register-op field
//   TIMEOUT  unacknowledged request cycles before error (1..255)
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   i_run            run enable (level)
//   i_ir             current IR from the datapath
//   i_mem_ack        memory acknowledge (read data valid same cycle)
//   i_ex_done        datapath finished a memory-reference operation
//   o_mem_req        memory read request
//   o_addr_sel       address source: 0 = PC, 1 = AR
//   o_ld_ir          load IR from memory data
//   o_inc_pc         increment PC
//   o_ld_ar          load AR from memory data (indirect address)
//   o_clr_pc         clear PC (first start after reset only)
//   o_mem_op         one-hot AND/ADD/LDA/STA/BUN/BSA/ISZ strobe
//   o_reg_op         register-reference strobe (ir[DW-5:0])
//   o_busy           state is neither IDLE nor HALT
//   o_halted         state is HALT
//   o_err            sticky timeout error
//   o_state          current state encoding (debug)
// ---------------------------------------------------------------------------
module ctrl_seq #(
   parameter int DW      = 16,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_run,
   input  logic [DW-1:0] i_ir,
   input  logic          i_mem_ack,
   input  logic          i_ex_done,
   output logic          o_mem_req,
   output logic          o_addr_sel,
   output logic          o_ld_ir,
   output logic          o_inc_pc,
   output logic          o_ld_ar,
   output logic          o_clr_pc,
   output logic [6:0]    o_mem_op,
   output logic [DW-5:0] o_reg_op,
   output logic          o_busy,
   output logic          o_halted,
   output logic          o_err,
   output logic [2:0]    o_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_DECODE   = 3'd2,
      S_INDIRECT = 3'd3,
      S_EXEC_MEM = 3'd4,
      S_EXEC_REG = 3'd5,
      S_HALT     = 3'd6
   } state_t;

   state_t     state, state_nxt;
   logic       first;      // set by reset, cleared on the first IDLE->FETCH
   logic       first_clr;
   logic       to_hit;     // watchdog expires at this clock edge
   logic       ind_bit;
   logic [2:0] opcode;
   logic       op_halt;

   assign ind_bit = i_ir[DW-1];
   assign opcode  = i_ir[DW-2:DW-4];
   assign op_halt = i_ir[0];

   // ------------------------------------------------------------------
   // Memory-timeout watchdog
   // ------------------------------------------------------------------
`ifdef CTRL_TIMEOUT_EN
   logic [7:0] to_cnt;
   logic       req_wait;
   logic       err;

   // Only FETCH and INDIRECT request memory, so the wait condition comes
   // straight from the state rather than from the o_mem_req output.
   assign req_wait = ((state == S_FETCH) || (state == S_INDIRECT)) && !i_mem_ack;
   // The counter value after this edge would equal TIMEOUT: that is the
   // TIMEOUT-th consecutive unacknowledged request cycle.
   assign to_hit   = req_wait && (to_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt <= 8'd0;
      end else if (i_mem_ack || (state_nxt != state)) begin
         to_cnt <= 8'd0;
      end else if (req_wait) begin
         to_cnt <= to_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    err <= 1'b0;
      else if (to_hit) err <= 1'b1;
   end

   assign o_err = err;
`else
   assign to_hit = 1'b0;
   assign o_err  = 1'b0;
`endif

   // ------------------------------------------------------------------
   // State register and start-up flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       first <= 1'b1;
      else if (first_clr) first <= 1'b0;
   end

   // ------------------------------------------------------------------
   // Next state and decoded outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      first_clr  = 1'b0;
      o_mem_req  = 1'b0;
      o_addr_sel = 1'b0;
      o_ld_ir    = 1'b0;
      o_inc_pc   = 1'b0;
      o_ld_ar    = 1'b0;
      o_clr_pc   = 1'b0;
      o_mem_op   = 7'd0;
      o_reg_op   = '0;

      case (state)
         S_IDLE: begin
            if (i_run) begin
               state_nxt = S_FETCH;
               first_clr = 1'b1;
               // Gated by reset_n so o_clr_pc stays low while reset is held
               // even if i_run is already high.
               o_clr_pc  = first && reset_n;
            end
         end

         S_FETCH: begin
            o_mem_req = 1'b1;
            if (i_mem_ack) begin
               o_ld_ir   = 1'b1;
               o_inc_pc  = 1'b1;
               state_nxt = S_DECODE;
            end
         end

         S_DECODE: begin
            if (opcode == 3'd7 && op_halt) state_nxt = S_HALT;
            else if (opcode == 3'd7)       state_nxt = S_EXEC_REG;
            else if (ind_bit)              state_nxt = S_INDIRECT;
            else                           state_nxt = S_EXEC_MEM;
         end

         S_INDIRECT: begin
            o_mem_req  = 1'b1;
            o_addr_sel = 1'b1;
            if (i_mem_ack) begin
               o_ld_ar   = 1'b1;
               state_nxt = S_EXEC_MEM;
            end
         end

         S_EXEC_MEM: begin
            // Opcode 7 never reaches this state; its shift would fall off the
            // top of the 7-bit vector anyway.
            o_mem_op = 7'b1 << opcode;
            if (i_ex_done) state_nxt = i_run ? S_FETCH : S_IDLE;
         end

         S_EXEC_REG: begin
            o_reg_op  = i_ir[DW-5:0];
            state_nxt = i_run ? S_FETCH : S_IDLE;
         end

         S_HALT: begin
            if (!i_run) state_nxt = S_IDLE;
         end

         default: state_nxt = S_IDLE;   // illegal encoding 7
      endcase

      if (to_hit) state_nxt = S_HALT;
   end

   assign o_busy   = (state != S_IDLE) && (state != S_HALT);
   assign o_halted = (state == S_HALT);
   assign o_state  = state;

endmodule

// File: tb/tb_ctrl_seq.sv
module tb_ctrl_seq;

   localparam int DW = 16;
`ifdef CTRL_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 15;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          i_run;
   logic [DW-1:0] i_ir;
   logic          i_mem_ack;
   logic          i_ex_done;
   logic          o_mem_req, o_addr_sel, o_ld_ir, o_inc_pc, o_ld_ar, o_clr_pc;
   logic [6:0]    o_mem_op;
   logic [DW-5:0] o_reg_op;
   logic          o_busy, o_halted, o_err;
   logic [2:0]    o_state;

   ctrl_seq #(.DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_ir(i_ir),
      .i_mem_ack(i_mem_ack), .i_ex_done(i_ex_done),
      .o_mem_req(o_mem_req), .o_addr_sel(o_addr_sel), .o_ld_ir(o_ld_ir),
      .o_inc_pc(o_inc_pc), .o_ld_ar(o_ld_ar), .o_clr_pc(o_clr_pc),
      .o_mem_op(o_mem_op), .o_reg_op(o_reg_op), .o_busy(o_busy),
      .o_halted(o_halted), .o_err(o_err), .o_state(o_state)
   );

   always #5 clk = ~clk;

   // strobe group order: {req, addr_sel, ld_ir, inc_pc, ld_ar, clr_pc}
   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] CLR  = 6'b000001;
   localparam logic [5:0] REQ  = 6'b100000;
   localparam logic [5:0] FACK = 6'b101100;
   localparam logic [5:0] IREQ = 6'b110000;
   localparam logic [5:0] IACK = 6'b110010;

   typedef struct {
      logic        run;
      logic [15:0] ir;
      logic        ack;
      logic        exd;
      logic [2:0]  st;
      logic [5:0]  str;
      logic [6:0]  mop;
      logic [11:0] rop;
   } vec_t;

   vec_t tv[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   wire [30:0] act = {o_state, o_mem_req, o_addr_sel, o_ld_ir, o_inc_pc,
                      o_ld_ar, o_clr_pc, o_mem_op, o_reg_op,
                      o_busy, o_halted, o_err};

   function automatic logic [30:0] expv(logic [2:0] st, logic [5:0] str,
                                        logic [6:0] mop, logic [11:0] rop,
                                        logic err);
      logic busy, halt;
      busy = (st != 3'd0) && (st != 3'd6);
      halt = (st == 3'd6);
      return {st, str, mop, rop, busy, halt, err};
   endfunction

   task automatic chk(input string name, input logic [30:0] a, input logic [30:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   task automatic add(input logic run, input logic [15:0] ir, input logic ack,
                      input logic exd, input logic [2:0] st, input logic [5:0] str,
                      input logic [6:0] mop, input logic [11:0] rop);
      vec_t v;
      v.run = run; v.ir = ir; v.ack = ack; v.exd = exd;
      v.st = st; v.str = str; v.mop = mop; v.rop = rop;
      tv.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit ok;
      // run ir ack exd | state strobes mem_op reg_op
      // register-reference 0x7020, zero-wait ack, first start clears PC
      add(1, 16'h7020, 1, 0, 3'd0, CLR,  7'h00, 12'h000);
      add(1, 16'h7020, 1, 0, 3'd1, FACK, 7'h00, 12'h000);
      add(1, 16'h7020, 1, 0, 3'd2, NONE, 7'h00, 12'h000);
      add(1, 16'h7020, 1, 0, 3'd5, NONE, 7'h00, 12'h020);
      // indirect ADD 0x9123, 2 wait cycles in FETCH and INDIRECT
      add(1, 16'h9123, 0, 0, 3'd1, REQ,  7'h00, 12'h000);
      add(1, 16'h9123, 0, 0, 3'd1, REQ,  7'h00, 12'h000);
      add(1, 16'h9123, 1, 0, 3'd1, FACK, 7'h00, 12'h000);
      add(1, 16'h9123, 0, 0, 3'd2, NONE, 7'h00, 12'h000);
      add(1, 16'h9123, 0, 0, 3'd3, IREQ, 7'h00, 12'h000);
      add(1, 16'h9123, 0, 0, 3'd3, IREQ, 7'h00, 12'h000);
      add(1, 16'h9123, 1, 0, 3'd3, IACK, 7'h00, 12'h000);
      add(1, 16'h9123, 0, 0, 3'd4, NONE, 7'h02, 12'h000);  // 8th cycle after FETCH entry
      add(1, 16'h9123, 0, 0, 3'd4, NONE, 7'h02, 12'h000);
      add(1, 16'h9123, 0, 1, 3'd4, NONE, 7'h02, 12'h000);
      // HALT 0x7001, then restart without clr_pc
      add(1, 16'h7001, 1, 0, 3'd1, FACK, 7'h00, 12'h000);
      add(1, 16'h7001, 0, 0, 3'd2, NONE, 7'h00, 12'h000);
      add(1, 16'h7001, 0, 0, 3'd6, NONE, 7'h00, 12'h000);
      add(1, 16'h7001, 0, 0, 3'd6, NONE, 7'h00, 12'h000);
      add(0, 16'h7001, 0, 0, 3'd6, NONE, 7'h00, 12'h000);
      add(0, 16'h7001, 0, 0, 3'd0, NONE, 7'h00, 12'h000);
      add(1, 16'h2050, 0, 0, 3'd0, NONE, 7'h00, 12'h000);
      // LDA 0x2050, run dropped in EXEC_MEM, stray ack ignored
      add(1, 16'h2050, 1, 0, 3'd1, FACK, 7'h00, 12'h000);
      add(1, 16'h2050, 0, 0, 3'd2, NONE, 7'h00, 12'h000);
      add(0, 16'h2050, 0, 0, 3'd4, NONE, 7'h04, 12'h000);
      add(0, 16'h2050, 1, 0, 3'd4, NONE, 7'h04, 12'h000);
      add(0, 16'h2050, 0, 1, 3'd4, NONE, 7'h04, 12'h000);
      add(0, 16'h2050, 1, 1, 3'd0, NONE, 7'h00, 12'h000);
      // ISZ 0x6777, ex_done in DECODE ignored
      add(1, 16'h6777, 0, 0, 3'd0, NONE, 7'h00, 12'h000);
      add(1, 16'h6777, 1, 0, 3'd1, FACK, 7'h00, 12'h000);
      add(1, 16'h6777, 0, 1, 3'd2, NONE, 7'h00, 12'h000);
      add(1, 16'h6777, 0, 1, 3'd4, NONE, 7'h40, 12'h000);
      // BSA 0x5ABC
      add(1, 16'h5ABC, 1, 0, 3'd1, FACK, 7'h00, 12'h000);
      add(1, 16'h5ABC, 0, 0, 3'd2, NONE, 7'h00, 12'h000);
      add(1, 16'h5ABC, 0, 1, 3'd4, NONE, 7'h20, 12'h000);
      // register op 0x7400 with run low: finishes, then IDLE
      add(0, 16'h7400, 1, 0, 3'd1, FACK, 7'h00, 12'h000);
      add(0, 16'h7400, 0, 0, 3'd2, NONE, 7'h00, 12'h000);
      add(0, 16'h7400, 0, 0, 3'd5, NONE, 7'h00, 12'h400);
      add(0, 16'h7400, 0, 0, 3'd0, NONE, 7'h00, 12'h000);

      reset_n = 1'b0; i_run = 1'b0; i_ir = '0; i_mem_ack = 1'b0; i_ex_done = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_state", act, 31'd0);
      step();
      reset_n = 1'b1;

      foreach (tv[i]) begin
         i_run = tv[i].run; i_ir = tv[i].ir; i_mem_ack = tv[i].ack; i_ex_done = tv[i].exd;
         #2;
         chk($sformatf("vec%0d", i), act, expv(tv[i].st, tv[i].str, tv[i].mop, tv[i].rop, 1'b0));
         step();
      end

      // reset pulsed during INDIRECT
      i_run = 1'b1; i_ir = 16'h8010; i_mem_ack = 1'b1; i_ex_done = 1'b0;
      step();                       // IDLE -> FETCH
      step();                       // FETCH ack -> DECODE
      i_mem_ack = 1'b0;
      step();                       // DECODE -> INDIRECT
      #1;
      chk("indirect_reached", act, expv(3'd3, IREQ, 7'h00, 12'h000, 1'b0));
      reset_n = 1'b0;
      #1;
      chk("reset_mid_indirect", act, 31'd0);
      step();
      reset_n = 1'b1;
      #1;
      chk("first_after_reset", act, expv(3'd0, CLR, 7'h00, 12'h000, 1'b0));
      step();                       // IDLE -> FETCH, ack never comes

`ifdef CTRL_TIMEOUT_EN
      repeat (TO - 1) step();
      #1;
      chk("timeout_pending", act, expv(3'd1, REQ, 7'h00, 12'h000, 1'b0));
      step();
      #1;
      chk("timeout_halt", act, expv(3'd6, NONE, 7'h00, 12'h000, 1'b1));
      i_run = 1'b0;
      step();
      #1;
      chk("err_sticky", act, expv(3'd0, NONE, 7'h00, 12'h000, 1'b1));
`else
      ok = 1'b1;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (act !== expv(3'd1, REQ, 7'h00, 12'h000, 1'b0)) ok = 1'b0;
         step();
      end
      #1;
      chk("wait_forever", {30'd0, ok}, 31'd1);
      chk("wait_forever_state", act, expv(3'd1, REQ, 7'h00, 12'h000, 1'b0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
